gpio_sw_debounce: RTL and testbench

Conditions the raw SW5 push-button input (GPIO_SW_N, logic high when pressed) for use in the clk200 domain. Synchronises the asynchronous pin, debounces it with a stability counter and FSM, and emits a clean level, single-cycle press and release strobes, a wrapping press counter, and optionally a long-press strobe. Sits between the top-level button pin and downstream consumers: PLL reset sequencing, counter clear, PMOD1 pattern select.

---
 rtl/gpio_sw_debounce.sv | 158 +++++++++++++++
 tb/tb_gpio_sw_debounce.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_sw_debounce.sv
// SW5 push-button conditioner: 2-flop sync, stability-counter debounce FSM, strobes and press counter.
// Optional long-press strobe is built when GPIO_SW_LONG_PRESS_EN is defined.
module gpio_sw_debounce #(
    parameter int DEBOUNCE_CYCLES   = 2_000_000,
    parameter int LONG_PRESS_CYCLES = 200_000_000,
    parameter int CNT_W             = 8
) (
    input  logic             clk200,
    input  logic             rst200_n,
    input  logic             sw_async,
    output logic             sw_level,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             long_press_pulse,
    output logic [CNT_W-1:0] press_count
);

    localparam int SW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SW-1:0] STAB_LAST = SW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    logic             sync1_q, sw_s_q;
    logic [1:0]       state_q, state_d;
    logic [SW-1:0]    stab_q, stab_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk200) begin
        if (!rst200_n) begin
            sync1_q <= 1'b0;
            sw_s_q  <= 1'b0;
        end else begin
            sync1_q <= sw_async;
            sw_s_q  <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (sw_s_q) begin
                    state_d = ST_PRESS_WAIT;
                    stab_d  = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!sw_s_q) begin
                    state_d = ST_IDLE;
                end else if (stab_q == STAB_LAST) begin
                    state_d = ST_PRESSED;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!sw_s_q) begin
                    state_d = ST_RELEASE_WAIT;
                    stab_d  = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                // A bounce back high returns to PRESSED without touching the hold timer.
                if (sw_s_q) begin
                    state_d = ST_PRESSED;
                end else if (stab_q == STAB_LAST) begin
                    state_d = ST_IDLE;
                    level_d = 1'b0;
                    rel_d   = 1'b1;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk200) begin
        if (!rst200_n) begin
            state_q <= ST_IDLE;
            stab_q  <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            stab_q  <= stab_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sw_level      = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign press_count   = cnt_q;

`ifdef GPIO_SW_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_PRESS_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          fired_q, fired_d;
    logic          long_q, long_d;

    // press_d marks the PRESS_WAIT -> PRESSED entry, which restarts the hold timer.
    always_comb begin
        hold_d  = hold_q;
        fired_d = fired_q;
        long_d  = 1'b0;
        if (press_d) begin
            hold_d  = '0;
            fired_d = 1'b0;
        end else if ((state_q == ST_PRESSED || state_q == ST_RELEASE_WAIT) && !fired_q) begin
            if (hold_q == HOLD_LAST) begin
                long_d  = 1'b1;
                fired_d = 1'b1;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk200) begin
        if (!rst200_n) begin
            hold_q  <= '0;
            fired_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            fired_q <= fired_d;
            long_q  <= long_d;
        end
    end

    assign long_press_pulse = long_q;
`else
    assign long_press_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_sw_debounce.sv
// Scoreboard bench for gpio_sw_debounce: run-length reference model feeds an expectation queue,
// a negedge monitor pops and compares; directed scenarios plus randomized button activity.
module tb_gpio_sw_debounce;

    localparam int D  = 4;
    localparam int L  = 20;
    localparam int CW = 3;

    logic          clk200 = 1'b0;
    logic          rst200_n = 1'b0;
    logic          sw_async = 1'b0;
    logic          sw_level, press_pulse, release_pulse, long_press_pulse;
    logic [CW-1:0] press_count;

    int checks = 0;
    int errors = 0;

    gpio_sw_debounce #(
        .DEBOUNCE_CYCLES  (D),
        .LONG_PRESS_CYCLES(L),
        .CNT_W            (CW)
    ) dut (
        .clk200          (clk200),
        .rst200_n        (rst200_n),
        .sw_async        (sw_async),
        .sw_level        (sw_level),
        .press_pulse     (press_pulse),
        .release_pulse   (release_pulse),
        .long_press_pulse(long_press_pulse),
        .press_count     (press_count)
    );

    always #5 clk200 = ~clk200;

    typedef struct packed {
        logic          lvl;
        logic          pp;
        logic          rp;
        logic          lp;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t expq[$];

    // Reference model: the pin is seen two edges late; the level flips once D+1
    // consecutive seen samples disagree with it.
    bit            sq[$];
    logic          m_lvl = 1'b0;
    logic [CW-1:0] m_cnt = '0;
    int            m_run = 0;
    int            m_cyc = 0;
    int            m_press_cyc = 0;
    bit            m_fired = 1'b1;

    always @(posedge clk200) begin
        exp_t e;
        bit   s;
        m_cyc++;
        e = '0;
        if (!rst200_n) begin
            sq.delete();
            sq.push_back(1'b0);
            sq.push_back(1'b0);
            m_lvl   = 1'b0;
            m_cnt   = '0;
            m_run   = 0;
            m_fired = 1'b1;
        end else begin
            s = sq.pop_front();
            sq.push_back(sw_async);
`ifdef GPIO_SW_LONG_PRESS_EN
            if (m_lvl && !m_fired && (m_cyc - m_press_cyc) == L) begin
                e.lp    = 1'b1;
                m_fired = 1'b1;
            end
`endif
            if (s != m_lvl) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_run = 0;
                    m_lvl = s;
                    if (s) begin
                        e.pp        = 1'b1;
                        m_cnt       = m_cnt + 1'b1;
                        m_press_cyc = m_cyc;
                        m_fired     = 1'b0;
                    end else begin
                        e.rp = 1'b1;
                    end
                end
            end else begin
                m_run = 0;
            end
        end
        e.lvl = m_lvl;
        e.cnt = m_cnt;
        expq.push_back(e);
    end

    always @(negedge clk200) begin
        exp_t e, a;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            a = {sw_level, press_pulse, release_pulse, long_press_pulse, press_count};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs @%0t: got lvl/pp/rp/lp/cnt=%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d",
                         $time, a.lvl, a.pp, a.rp, a.lp, a.cnt, e.lvl, e.pp, e.rp, e.lp, e.cnt);
            end
            checks++;
            if (press_pulse && release_pulse) begin
                errors++;
                $display("FAIL strobe_overlap @%0t: got both strobes high expected at most one", $time);
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic wait_pulse(input bit rel, input int maxc, output int lat);
        lat = 0;
        do begin
            @(negedge clk200);
            lat++;
        end while (!(rel ? release_pulse : press_pulse) && lat < maxc);
    endtask

    int lat, nstb, nl, at;
    int seq[9];

    initial begin
        rst200_n = 1'b0;
        sw_async = 1'b0;
        repeat (3) @(negedge clk200);
        check("reset_state", int'({sw_level, press_pulse, release_pulse, long_press_pulse, press_count}), 0);
        rst200_n = 1'b1;
        repeat (2) @(negedge clk200);

        // clean press / release
        sw_async = 1'b1;
        wait_pulse(1'b0, 30, lat);
        check("press_latency", lat, 7);
        check("press_level", int'(sw_level), 1);
        check("press_count_1", int'(press_count), 1);
        repeat (3) @(negedge clk200);
        sw_async = 1'b0;
        wait_pulse(1'b1, 30, lat);
        check("release_latency", lat, 7);
        check("release_level", int'(sw_level), 0);
        repeat (3) @(negedge clk200);

        // bounce rejection
        nstb = 0;
        for (int i = 0; i < 30; i++) begin
            sw_async = (i < 20) ? ((i / 2) % 2 == 0) : 1'b0;
            @(negedge clk200);
            if (press_pulse || release_pulse) nstb++;
        end
        check("bounce_strobes", nstb, 0);
        check("bounce_level", int'(sw_level), 0);
        check("bounce_count", int'(press_count), 1);

        // release glitch
        sw_async = 1'b1;
        wait_pulse(1'b0, 30, lat);
        repeat (3) @(negedge clk200);
        sw_async = 1'b0;
        repeat (2) @(negedge clk200);
        sw_async = 1'b1;
        nstb = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk200);
            if (release_pulse) nstb++;
        end
        check("glitch_release_strobes", nstb, 0);
        check("glitch_level", int'(sw_level), 1);
        sw_async = 1'b0;
        wait_pulse(1'b1, 30, lat);
        check("glitch_clean_release", lat, 7);
        repeat (3) @(negedge clk200);

        // counter wrap from a fresh reset
        rst200_n = 1'b0;
        repeat (2) @(negedge clk200);
        rst200_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            sw_async = 1'b1;
            wait_pulse(1'b0, 30, lat);
            seq[i] = int'(press_count);
            repeat (2) @(negedge clk200);
            sw_async = 1'b0;
            wait_pulse(1'b1, 30, lat);
            repeat (2) @(negedge clk200);
        end
        check("wrap_seq_6", seq[6], 7);
        check("wrap_seq_7", seq[7], 0);
        check("wrap_seq_8", seq[8], 1);

        // reset in PRESS_WAIT with the button held
        sw_async = 1'b1;
        repeat (4) @(negedge clk200);
        rst200_n = 1'b0;
        @(negedge clk200);
        check("reset_mid_press", int'({sw_level, press_pulse, release_pulse, long_press_pulse, press_count}), 0);
        rst200_n = 1'b1;
        wait_pulse(1'b0, 30, lat);
        check("press_after_reset_latency", lat, 7);
        check("press_after_reset_count", int'(press_count), 1);
        sw_async = 1'b0;
        wait_pulse(1'b1, 30, lat);
        repeat (3) @(negedge clk200);

        // long press
        sw_async = 1'b1;
        wait_pulse(1'b0, 30, lat);
        nl = 0;
        at = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk200);
            if (long_press_pulse) begin
                nl++;
                at = k;
            end
        end
`ifdef GPIO_SW_LONG_PRESS_EN
        check("long_press_count", nl, 1);
        check("long_press_offset", at, L);
`else
        check("long_press_count", nl, 0);
`endif
        sw_async = 1'b0;
        wait_pulse(1'b1, 30, lat);
        repeat (3) @(negedge clk200);

        // randomized activity with occasional resets
        for (int i = 0; i < 250; i++) begin
            int r, n;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                rst200_n = 1'b0;
                n = $urandom_range(1, 2);
                repeat (n) @(negedge clk200);
                rst200_n = 1'b1;
            end
            sw_async = 1'($urandom_range(0, 1));
            n = (r < 3) ? $urandom_range(20, 30) : $urandom_range(1, 10);
            repeat (n) @(negedge clk200);
        end
        sw_async = 1'b0;
        repeat (20) @(negedge clk200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
